// File: rtl/conv_pkg.sv
// Shared definitions for the conv/pool input datapath: pixel and tile geometry,
// the tile fetcher state encoding and the [r*32 + c*8] tile packing helper.
package conv_pkg;
  localparam int PIX_W      = 8;
  localparam int TILE_DIM   = 4;
  localparam int TILE_BYTES = 16;

  typedef logic [TILE_BYTES*PIX_W-1:0] tile_t;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} fetch_state_t;

  // Bit offset of pixel (r,c) inside a packed tile: r*32 + c*8.
  function automatic logic [6:0] pix_lsb(input logic [1:0] r, input logic [1:0] c);
    return {r, c, 3'b000};
  endfunction
endpackage

// File: rtl/conv_tile_addr_gen.sv
// Tile/row/column counters and pixel address generation for conv_tile_fetch.
// With TILE_REUSE_EN defined, tiles with tx > 0 only walk columns 2..3.
module conv_tile_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 34,
  parameter int IMG_H  = 34,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              next_tile,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        r,
  output logic [1:0]        c,
  output logic [15:0]       tile_idx,
  output logic              last_read,
  output logic              last_tile
`ifdef TILE_REUSE_EN
  ,
  output logic              row_end
`endif
);
  localparam int TILES_X = (IMG_W - 2) / 2;
  localparam int TILES_Y = (IMG_H - 2) / 2;
  localparam logic [15:0]       TX_LAST   = 16'(TILES_X - 1);
  localparam logic [15:0]       TY_LAST   = 16'(TILES_Y - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(2);

  logic [15:0]       tx, ty;
  logic [ADDR_W-1:0] row_base, row_off, col_base;
  logic [1:0]        c_lo, c_lo_next;
  logic              tx_end;

  assign tx_end = (tx == TX_LAST);

`ifdef TILE_REUSE_EN
  // Columns 0,1 of a tx > 0 tile are inherited from the previous tile.
  assign row_end   = tx_end;
  assign c_lo      = (tx == 16'd0) ? 2'd0 : 2'd2;
  assign c_lo_next = tx_end ? 2'd0 : 2'd2;
`else
  assign c_lo      = 2'd0;
  assign c_lo_next = 2'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= '0; ty <= '0; r <= '0; c <= '0; tile_idx <= '0;
      row_base <= '0; row_off <= '0; col_base <= '0;
    end else if (clear) begin
      tx <= '0; ty <= '0; r <= '0; c <= '0; tile_idx <= '0;
      row_base <= '0; row_off <= '0; col_base <= '0;
    end else if (next_tile) begin
      r        <= '0;
      row_off  <= '0;
      c        <= c_lo_next;
      tile_idx <= tile_idx + 16'd1;
      if (tx_end) begin
        tx       <= '0;
        ty       <= ty + 16'd1;
        col_base <= '0;
        row_base <= row_base + BAND_STEP;
      end else begin
        tx       <= tx + 16'd1;
        col_base <= col_base + COL_STEP;
      end
    end else if (step) begin
      if (c == 2'd3) begin
        c       <= c_lo;
        r       <= r + 2'd1;
        row_off <= (r == 2'd3) ? '0 : row_off + ROW_STEP;
      end else begin
        c <= c + 2'd1;
      end
    end
  end

  assign mem_addr  = row_base + row_off + col_base + ADDR_W'(c);
  assign last_read = (r == 2'd3) && (c == 2'd3);
  assign last_tile = tx_end && (ty == TY_LAST);
endmodule

// File: rtl/conv_tile_fetch.sv
// Fetches overlapping 4x4 stride-2 tiles from byte-wide SRAM and presents them
// on a valid/ready port. Define TILE_REUSE_EN to reuse columns 2,3 across tiles.
module conv_tile_fetch
  import conv_pkg::*;
#(
  parameter int IMG_W  = 34,
  parameter int IMG_H  = 34,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [127:0]      tile_data,
  output logic [15:0]       tile_addr
);
  fetch_state_t state, state_next;
  logic         clear, step, hs;
  logic         last_read, last_tile;
  logic [1:0]   r, c;
  logic [1:0]   r_p0, c_p0;
  logic         vld_p0;
`ifdef TILE_REUSE_EN
  logic         row_end;
`endif

  assign clear = (state == IDLE) && start;
  assign step  = (state == FETCH);
  assign hs    = (state == PRESENT) && tile_ready;

  conv_tile_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .step      (step),
    .next_tile (hs),
    .mem_addr  (mem_addr),
    .r         (r),
    .c         (c),
    .tile_idx  (tile_addr),
    .last_read (last_read),
    .last_tile (last_tile)
`ifdef TILE_REUSE_EN
    ,
    .row_end   (row_end)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (last_read) state_next = DRAIN;
      DRAIN:   state_next = PRESENT;
      PRESENT: if (tile_ready) state_next = last_tile ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_re     = (state == FETCH);
  assign tile_valid = (state == PRESENT);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

  // p0: slot of the read issued last cycle; its byte arrives on mem_rdata now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0    <= 1'b0;
      r_p0      <= '0;
      c_p0      <= '0;
      tile_data <= '0;
    end else begin
      vld_p0 <= step;
      r_p0   <= r;
      c_p0   <= c;
      if (vld_p0) tile_data[pix_lsb(r_p0, c_p0) +: PIX_W] <= mem_rdata;
`ifdef TILE_REUSE_EN
      if (hs && !row_end)
        for (int i = 0; i < TILE_DIM; i++)
          tile_data[i*32 +: 16] <= tile_data[i*32+16 +: 16];
`endif
    end
  end
endmodule

// File: tb/tb_conv_tile_fetch.sv
// Self-checking bench for conv_tile_fetch on a 6x6 image (2x2 tiles); honours
// TILE_REUSE_EN for the expected read pattern, tile contents are build-independent.
module tb_conv_tile_fetch;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int TX = (W - 2) / 2;
  localparam int TY = (H - 2) / 2;
`ifdef TILE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic         clk, rst, start, busy, done, mem_re, tile_valid, tile_ready;
  logic [15:0]  mem_addr, tile_addr;
  logic [7:0]   mem_rdata;
  logic [127:0] tile_data;

  logic [7:0]   mem   [0:W*H-1];
  logic [127:0] tiles [0:TX*TY-1];
  int ncomp = 0;
  int nfail = 0;
  int done_cnt = 0;

  conv_tile_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .tile_addr  (tile_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_tile(input int ty, input int tx);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r*32 + c*8 +: 8] = mem[(2*ty + r)*W + 2*tx + c];
    return t;
  endfunction

  // Entered at the first negedge after the accepting edge; leaves at the
  // first negedge after the handshake edge.
  task automatic fetch_tile(input int ty, input int tx, input int hold,
                            input bit poke_start, output logic [127:0] got);
    int c0;
    logic [127:0] held;
    logic [15:0]  haddr;
    c0 = (REUSE && tx > 0) ? 2 : 0;
    for (int r = 0; r < 4; r++)
      for (int c = c0; c < 4; c++) begin
        chk("fetch_mem_re", mem_re, 1);
        chk("fetch_mem_addr", mem_addr, (2*ty + r)*W + 2*tx + c);
        @(negedge clk);
      end
    chk("drain_quiet", {tile_valid, mem_re}, 0);
    if (hold > 0) tile_ready = 1'b0;
    @(negedge clk);
    chk("valid_rise", tile_valid, 1);
    chk("tile_data", tile_data, model_tile(ty, tx));
    chk("tile_addr", tile_addr, ty*TX + tx);
    got   = tile_data;
    held  = tile_data;
    haddr = tile_addr;
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid_nore", {tile_valid, mem_re}, 2'b10);
      chk("hold_data", tile_data, held);
      chk("hold_addr", tile_addr, haddr);
    end
    tile_ready = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: always ready; 1: backpressure + start poke on tile 1; 2: random holds
  task automatic run_frame(input int mode);
    int d0, hold;
    bit poke;
    logic [127:0] got;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    d0 = done_cnt;
    for (int ty = 0; ty < TY; ty++)
      for (int tx = 0; tx < TX; tx++) begin
        hold = 0;
        poke = 1'b0;
        if (mode == 1 && ty == 0 && tx == 1) begin hold = 5; poke = 1'b1; end
        if (mode == 2) hold = $urandom_range(0, 3);
        fetch_tile(ty, tx, hold, poke, got);
        tiles[ty*TX + tx] = got;
      end
    chk("done_high", {done, busy, mem_re}, 3'b110);
    @(negedge clk);
    chk("done_low_idle", {done, busy, tile_valid}, 0);
    @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) mem[i] = 8'(i);
    rst = 1'b0; start = 1'b0; tile_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {tile_valid, mem_re, busy, done, tile_addr, mem_addr}, 0);
    chk("reset_data", tile_data, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_quiet", {busy, mem_re, tile_valid}, 0);

    run_frame(0);
    chk("t0_b0",   tiles[0][7:0],     8'h00);
    chk("t0_b4",   tiles[0][39:32],   8'h06);
    chk("t0_b15",  tiles[0][127:120], 8'h15);
    chk("t1_b0",   tiles[1][7:0],     8'h02);
    chk("t1_b15",  tiles[1][127:120], 8'h17);
    chk("t2_b0",   tiles[2][7:0],     8'h0C);

    run_frame(1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midfetch_re", mem_re, 1);
    rst = 1'b0;
    #1;
    chk("async_reset_outs", {tile_valid, mem_re, busy, done, tile_addr, mem_addr}, 0);
    chk("async_reset_data", tile_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, mem_re}, 0);

    for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
    run_frame(2);
    chk("rand_t0_b0", tiles[0][7:0], mem[0]);
    run_frame(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
